// File: rtl/scu_pkg.sv
// Shared types and default sizing for the SCU round-robin bus arbiter.
package scu_pkg;
  localparam int DEF_NUM_MASTERS = 4;
  localparam int DEF_MAX_HOLD    = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_e;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_pick #(
  parameter  int NUM_MASTERS = 4,
  localparam int IW          = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IW-1:0]          ptr,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [IW-1:0]          idx,
  output logic                   any
);
  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  // Scan from the farthest offset down so the closest requester to ptr wins last.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = |req;
    sum   = '0;
    cand  = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NUM_MASTERS)) sum = sum - (IW+1)'(NUM_MASTERS);
      cand = sum[IW-1:0];
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end
endmodule

// File: rtl/scu_rr_arb.sv
// Round-robin bus arbiter: registered one-hot grant, hold timeout, one dead cycle between owners.
module scu_rr_arb
  import scu_pkg::*;
#(
  parameter  int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter  int MAX_HOLD    = DEF_MAX_HOLD,
  localparam int IW          = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] sel,
  input  logic                   endtrans,
  output logic [NUM_MASTERS-1:0] mas_sel,
  output logic [IW-1:0]          gnt_idx,
  output logic                   gnt_vld,
  output logic                   timeout
);
  // A 1-bit counter stands in when the timeout is disabled; it then never moves.
  localparam int              CW       = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CW-1:0]   CNT_LAST = (MAX_HOLD > 0) ? CW'(MAX_HOLD - 1) : '0;
  localparam logic [CW-1:0]   CNT_MAX  = (MAX_HOLD > 0) ? CW'(MAX_HOLD) : '0;

  state_e                 state_q, state_d;
  logic [IW-1:0]          ptr_q, ptr_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NUM_MASTERS-1:0] mas_sel_q, mas_sel_d;
  logic [IW-1:0]          gnt_idx_q, gnt_idx_d;
  logic                   gnt_vld_q, gnt_vld_d;
  logic                   timeout_q, timeout_d;

  logic [NUM_MASTERS-1:0] pick_grant;
  logic [IW-1:0]          pick_idx;
  logic                   pick_any;
  logic [IW-1:0]          nxt_ptr;
  logic                   expire;

  rr_pick #(.NUM_MASTERS(NUM_MASTERS)) u_pick (
    .req   (sel),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    mas_sel_d = '0;
    gnt_idx_d = '0;
    gnt_vld_d = 1'b0;
    timeout_d = 1'b0;
    nxt_ptr   = (gnt_idx_q == IW'(NUM_MASTERS - 1)) ? '0 : gnt_idx_q + 1'b1;
    expire    = (MAX_HOLD > 0) && (cnt_q == CNT_LAST);

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d   = BUSY;
          mas_sel_d = pick_grant;
          gnt_idx_d = pick_idx;
          gnt_vld_d = 1'b1;
          cnt_d     = '0;
        end
      end
      BUSY: begin
        if (endtrans || expire) begin
          // A normal end wins over a coincident expiry, so no timeout pulse then.
          state_d   = RELEASE;
          ptr_d     = nxt_ptr;
          timeout_d = !endtrans;
        end else begin
          mas_sel_d = mas_sel_q;
          gnt_idx_d = gnt_idx_q;
          gnt_vld_d = gnt_vld_q;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      mas_sel_q <= '0;
      gnt_idx_q <= '0;
      gnt_vld_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      mas_sel_q <= mas_sel_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_vld_q <= gnt_vld_d;
      timeout_q <= timeout_d;
    end
  end

  assign mas_sel = mas_sel_q;
  assign gnt_idx = gnt_idx_q;
  assign gnt_vld = gnt_vld_q;
  assign timeout = timeout_q;
endmodule

// File: tb/tb_scu_rr_arb.sv
// Directed scoreboard bench for scu_rr_arb with NUM_MASTERS=4, MAX_HOLD=8.
module tb_scu_rr_arb;
  localparam int N  = 4;
  localparam int MH = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         endtrans = 1'b0;
  logic [N-1:0] sel = '0;
  logic [N-1:0] mas_sel;
  logic [1:0]   gnt_idx;
  logic         gnt_vld;
  logic         timeout;

  typedef struct {
    int         n;
    logic [3:0] mas;
    logic [1:0] idx;
    logic       vld;
    logic       to;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   stepn      = 0;

  scu_rr_arb #(.NUM_MASTERS(N), .MAX_HOLD(MH)) dut (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .endtrans (endtrans),
    .mas_sel  (mas_sel),
    .gnt_idx  (gnt_idx),
    .gnt_vld  (gnt_vld),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, queue what the outputs must be after the edge, then check.
  task automatic step(input logic r, input logic [3:0] s, input logic e,
                      input logic [3:0] em, input logic [1:0] ei, input logic et);
    exp_t x;
    @(negedge clk);
    stepn++;
    rst = r; sel = s; endtrans = e;
    x.n = stepn; x.mas = em; x.idx = ei; x.vld = |em; x.to = et;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    compared++;
    assert (mas_sel === x.mas) else begin
      mismatched++;
      $error("FAIL step%0d mas_sel observed=%b expected=%b", x.n, mas_sel, x.mas);
    end
    compared++;
    assert (gnt_idx === x.idx) else begin
      mismatched++;
      $error("FAIL step%0d gnt_idx observed=%0d expected=%0d", x.n, gnt_idx, x.idx);
    end
    compared++;
    assert (gnt_vld === x.vld) else begin
      mismatched++;
      $error("FAIL step%0d gnt_vld observed=%b expected=%b", x.n, gnt_vld, x.vld);
    end
    compared++;
    assert (timeout === x.to) else begin
      mismatched++;
      $error("FAIL step%0d timeout observed=%b expected=%b", x.n, timeout, x.to);
    end
    compared++;
    assert ($onehot0(mas_sel)) else begin
      mismatched++;
      $error("FAIL step%0d onehot mas_sel observed=%b expected=at most one bit", x.n, mas_sel);
    end
  endtask

  initial begin
    // reset dominates sel and endtrans
    step(1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0);
    // endtrans in IDLE ignored, no requests
    step(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0);
    // first grant from ptr 0
    step(1'b0, 4'b0101, 1'b0, 4'b0001, 2'd0, 1'b0);
    // owner drops request, grant held
    step(1'b0, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b0);
    // end of transaction -> RELEASE, ptr 1
    step(1'b0, 4'b0101, 1'b1, 4'b0000, 2'd0, 1'b0);
    // RELEASE -> IDLE, endtrans ignored
    step(1'b0, 4'b0101, 1'b1, 4'b0000, 2'd0, 1'b0);
    // ptr 1 skips idle master 1
    step(1'b0, 4'b0101, 1'b0, 4'b0100, 2'd2, 1'b0);
    step(1'b0, 4'b0101, 1'b1, 4'b0000, 2'd0, 1'b0);
    step(1'b0, 4'b1000, 1'b0, 4'b0000, 2'd0, 1'b0);
    step(1'b0, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b0);
    // owner 3 ends: ptr wraps to 0
    step(1'b0, 4'b1001, 1'b1, 4'b0000, 2'd0, 1'b0);
    step(1'b0, 4'b1001, 1'b0, 4'b0000, 2'd0, 1'b0);
    step(1'b0, 4'b1001, 1'b0, 4'b0001, 2'd0, 1'b0);
    // hold for MH cycles total, then timeout
    for (int i = 0; i < MH - 1; i++) step(1'b0, 4'b1001, 1'b0, 4'b0001, 2'd0, 1'b0);
    step(1'b0, 4'b1001, 1'b0, 4'b0000, 2'd0, 1'b1);
    step(1'b0, 4'b1001, 1'b0, 4'b0000, 2'd0, 1'b0);
    step(1'b0, 4'b1001, 1'b0, 4'b1000, 2'd3, 1'b0);
    // endtrans coincides with expiry: no timeout
    for (int i = 0; i < MH - 1; i++) step(1'b0, 4'b1001, 1'b0, 4'b1000, 2'd3, 1'b0);
    step(1'b0, 4'b1001, 1'b1, 4'b0000, 2'd0, 1'b0);
    step(1'b0, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0);
    step(1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b0);
    step(1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0);
    step(1'b0, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0);
    step(1'b0, 4'b1111, 1'b0, 4'b0010, 2'd1, 1'b0);
    // reset mid-BUSY: grant dropped at once, ptr back to 0
    step(1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0);
    step(1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/scu_rr_arb.md
SCU_RR_ARB -- requirements
Module: scu_rr_arb

Interface
REQ-001 Parameter NUM_MASTERS, default 4, number of requesting masters (2..16).
REQ-002 Parameter MAX_HOLD, default 16, maximum cycles a grant is held without endtrans; 0 disables timeout.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 sel  input  NUM_MASTERS  per-master request; bit i = master i requests the bus.
REQ-006 endtrans  input  1  owning master signals last cycle of its transaction.
REQ-007 mas_sel  output  NUM_MASTERS  one-hot grant, registered; all-zero = no owner.
REQ-008 gnt_idx  output  $clog2(NUM_MASTERS)  binary index of current owner; 0 when mas_sel is zero.
REQ-009 gnt_vld  output  1  high when mas_sel is non-zero.
REQ-010 timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD expiry.

Function
REQ-011 FSM shall have states IDLE, BUSY, RELEASE.
REQ-012 IDLE: if sel non-zero, pick winner round-robin starting at index ptr, wrapping NUM_MASTERS-1 to 0; next edge -> BUSY with mas_sel one-hot on winner.
REQ-013 Grant latency shall be exactly one cycle: sel sampled at edge k, mas_sel valid after edge k.
REQ-014 IDLE with sel zero: remain IDLE, mas_sel zero.
REQ-015 BUSY: grant held unchanged regardless of sel changes, including owner dropping its request.
REQ-016 BUSY: hold counter increments each cycle from 0 at grant entry.
REQ-017 BUSY with endtrans=1: next edge -> RELEASE, mas_sel zero, ptr = owner+1 mod NUM_MASTERS.
REQ-018 BUSY, MAX_HOLD>0, counter = MAX_HOLD-1, endtrans=0: next edge -> RELEASE, timeout=1 for one cycle, ptr = owner+1 mod NUM_MASTERS.
REQ-019 Simultaneous endtrans and expiry: treat as normal end; timeout shall stay 0.
REQ-020 RELEASE: one dead cycle, mas_sel zero, unconditional -> IDLE.
REQ-021 endtrans in IDLE or RELEASE shall be ignored.
REQ-022 Counter width $clog2(MAX_HOLD+1); shall not wrap; unused when MAX_HOLD=0.
REQ-023 mas_sel shall never have more than one bit set.

Reset
REQ-024 rst=1 at an edge: state IDLE, mas_sel 0, gnt_idx 0, gnt_vld 0, timeout 0, ptr 0, counter 0.
REQ-025 Reset mid-BUSY shall drop the grant at that edge with no RELEASE cycle and no timeout pulse.
REQ-026 rst shall dominate sel and endtrans in the same cycle.

Structure
REQ-027 Package scu_pkg shall hold the state enum (IDLE, BUSY, RELEASE) and default parameter constants.
REQ-028 Round-robin selection shall be a combinational sub-module rr_pick (inputs req, ptr; outputs one-hot grant, index, any).
REQ-029 All outputs shall be registered; no combinational path from sel to mas_sel.

Verification (NUM_MASTERS=4, MAX_HOLD=8)
REQ-030 After reset, sel=4'b0101 -> one edge later mas_sel=0001, gnt_idx=0, gnt_vld=1.
REQ-031 Owner 0 endtrans while sel=4'b0101 -> RELEASE cycle mas_sel=0, then mas_sel=0100 (ptr=1 skips idle master 1).
REQ-032 Grant to master 3, endtrans, sel=4'b1001 -> ptr wraps to 0, next grant mas_sel=0001.
REQ-033 Grant held 8 cycles without endtrans -> timeout pulse exactly one cycle, mas_sel=0, next grant to next requester.
REQ-034 endtrans and expiry on same cycle -> RELEASE, timeout stays 0.
REQ-035 rst asserted during BUSY with sel=4'b1111 -> mas_sel=0 next edge; after release, first grant to master 0.
